// File: rtl/common_pkg.sv
// rtl/common_pkg.sv - shared elaboration helpers: bit-index math and parameter checks
package common_pkg;

    function automatic int unsigned msb(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) r = i;
        end
        return r;
    endfunction

    function automatic bit check_param_range(input int unsigned v, input int unsigned lo,
                                             input int unsigned hi);
        return (v >= lo) && (v <= hi);
    endfunction

    function automatic bit check_param_pos2exp(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/cxu_arb_pkg.sv
// rtl/cxu_arb_pkg.sv - grant state type and modulo-N pointer helper for the CXU arbiter
package cxu_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } st_e;

    // Compare-and-clear rather than a bit mask so non-power-of-two n wraps correctly.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/cxu_arb_rr.sv
// rtl/cxu_arb_rr.sv - combinational round-robin winner select starting at prio_i
module cxu_arb_rr #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  prio_i,
    output logic [ID_W-1:0]  win_o,
    output logic             any_o
);

    int              idx;
    logic [ID_W-1:0] idx_w;

    // Scan offsets from the far end down so the smallest offset from prio_i wins.
    always_comb begin
        win_o = '0;
        any_o = |req_i;
        idx   = 0;
        idx_w = '0;
        for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
            idx = int'(prio_i) + k;
            if (idx >= int'(N_REQ)) idx = idx - int'(N_REQ);
            idx_w = ID_W'(idx);
            if (req_i[idx_w]) win_o = idx_w;
        end
    end

endmodule

// File: rtl/cxu_req_arbiter.sv
// rtl/cxu_req_arbiter.sv - round-robin sharing of one CXU among N_REQ requesters,
// with an in-order id FIFO that routes each response back to its originator.
module cxu_req_arbiter
    import common_pkg::*;
    import cxu_arb_pkg::*;
#(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned REQ_W        = 64,
    parameter int unsigned RESP_W       = 33,
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_v,
    output logic [N_REQ-1:0]         req_rdy,
    input  logic [N_REQ*REQ_W-1:0]   req_data,
    output logic                     cxu_req_v,
    input  logic                     cxu_req_rdy,
    output logic [REQ_W-1:0]         cxu_req_data,
    output logic [$clog2(N_REQ)-1:0] cxu_req_id,
    input  logic                     cxu_resp_v,
    output logic                     cxu_resp_rdy,
    input  logic [RESP_W-1:0]        cxu_resp_data,
    output logic [N_REQ-1:0]         resp_v,
    input  logic [N_REQ-1:0]         resp_rdy,
    output logic [RESP_W-1:0]        resp_data,
    output logic                     err
);

    localparam int unsigned ID_W  = msb(N_REQ - 1) + 1;
    localparam int unsigned PTR_W = (MAX_INFLIGHT > 1) ? msb(MAX_INFLIGHT - 1) + 1 : 1;
    localparam int unsigned CNT_W = msb(MAX_INFLIGHT) + 1;

    typedef logic [ID_W-1:0] req_id_t;

    if (!check_param_range(N_REQ, 2, 16)) begin : g_bad_n_req
        $error("N_REQ must be within 2..16");
    end
    if (!check_param_pos2exp(MAX_INFLIGHT)) begin : g_bad_inflight
        $error("MAX_INFLIGHT must be a positive power of two");
    end

    st_e              state_q, state_d;
    req_id_t          grant_q, grant_d;
    req_id_t          prio_q, prio_d;
    req_id_t          fifo_q [MAX_INFLIGHT];
    logic [PTR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q;
    logic             err_q;

    req_id_t          win, grant, head_id;
    logic             any, gnt_v, full, empty, space, push, pop;
    logic [REQ_W-1:0] req_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign req_arr[i] = req_data[i*REQ_W +: REQ_W];
    end

    cxu_arb_rr #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr (
        .req_i  (req_v),
        .prio_i (prio_q),
        .win_o  (win),
        .any_o  (any)
    );

    assign full    = (count_q == CNT_W'(MAX_INFLIGHT));
    assign empty   = (count_q == '0);
    assign head_id = fifo_q[head_q];

    // With the FIFO empty the response is swallowed so a stray CXU beat cannot wedge the port.
    assign cxu_resp_rdy = rst_n && (empty || resp_rdy[head_id]);
    assign resp_v       = (rst_n && !empty && cxu_resp_v) ? (N_REQ'(1) << head_id) : '0;
    assign resp_data    = cxu_resp_data;
    assign pop          = cxu_resp_v && cxu_resp_rdy && !empty;

    // A same-cycle pop frees a slot, so a full FIFO still accepts a push.
    assign space        = !full || pop;
    assign grant        = (state_q == LOCKED) ? grant_q : win;
    assign gnt_v        = (state_q == LOCKED) ? req_v[grant_q] : any;
    assign cxu_req_v    = rst_n && gnt_v && space;
    assign cxu_req_data = req_arr[grant];
    assign cxu_req_id   = grant;
    assign req_rdy      = (rst_n && cxu_req_rdy && space) ? (N_REQ'(1) << grant) : '0;
    assign push         = cxu_req_v && cxu_req_rdy;
    assign err          = err_q;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        prio_d  = prio_q;
        case (state_q)
            IDLE: begin
                if (cxu_req_v && !cxu_req_rdy) begin
                    state_d = LOCKED;
                    grant_d = win;
                end
            end
            LOCKED: begin
                if (push) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (push) prio_d = req_id_t'(rr_next(32'(grant), N_REQ));
    end

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            prio_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < MAX_INFLIGHT; i++) fifo_q[i] <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            prio_q  <= prio_d;
            if (push) begin
                fifo_q[tail_q] <= grant;
                tail_q         <= ptr_inc(tail_q);
            end
            if (pop) head_q <= ptr_inc(head_q);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (cxu_resp_v && empty) err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cxu_req_arbiter.sv
// tb/tb_cxu_req_arbiter.sv - self-checking bench for cxu_req_arbiter with id scoreboard
module tb_cxu_req_arbiter;

    localparam int N  = 4;
    localparam int RW = 64;
    localparam int SW = 33;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_v;
    logic [N-1:0]    req_rdy;
    logic [N*RW-1:0] req_data;
    logic            cxu_req_v;
    logic            cxu_req_rdy;
    logic [RW-1:0]   cxu_req_data;
    logic [1:0]      cxu_req_id;
    logic            cxu_resp_v;
    logic            cxu_resp_rdy;
    logic [SW-1:0]   cxu_resp_data;
    logic [N-1:0]    resp_v;
    logic [N-1:0]    resp_rdy;
    logic [SW-1:0]   resp_data;
    logic            err;

    int checks = 0;
    int errors = 0;
    int exp_ptr;
    int id_q[$];

    always #5 clk = ~clk;

    cxu_req_arbiter #(
        .N_REQ        (N),
        .REQ_W        (RW),
        .RESP_W       (SW),
        .MAX_INFLIGHT (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_v         (req_v),
        .req_rdy       (req_rdy),
        .req_data      (req_data),
        .cxu_req_v     (cxu_req_v),
        .cxu_req_rdy   (cxu_req_rdy),
        .cxu_req_data  (cxu_req_data),
        .cxu_req_id    (cxu_req_id),
        .cxu_resp_v    (cxu_resp_v),
        .cxu_resp_rdy  (cxu_resp_rdy),
        .cxu_resp_data (cxu_resp_data),
        .resp_v        (resp_v),
        .resp_rdy      (resp_rdy),
        .resp_data     (resp_data),
        .err           (err)
    );

    function automatic logic [RW-1:0] pay(input int i);
        return {32'hC0DE_0000, 32'(i)};
    endfunction

    function automatic int model_win(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_v         = '0;
        cxu_req_rdy   = 1'b0;
        cxu_resp_v    = 1'b0;
        resp_rdy      = '0;
        cxu_resp_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n   = 1'b1;
        exp_ptr = 0;
        id_q.delete();
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        req_v       = '1;
        cxu_req_rdy = 1'b1;
        cxu_resp_v  = 1'b1;
        resp_rdy    = '1;
        #1;
        checks++;
        if ({req_rdy, cxu_req_v, cxu_resp_rdy, resp_v, err} !== 11'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b req_rdy=%b cxu_req_v=%b cxu_resp_rdy=%b resp_v=%b err=%b exp all 0",
                     {req_rdy, cxu_req_v, cxu_resp_rdy, resp_v, err}, req_rdy, cxu_req_v, cxu_resp_rdy, resp_v, err);
        end
        do_reset();
    endtask

    task automatic test_round_robin();
        int e, h;
        logic [SW-1:0] rd;
        do_reset();
        resp_rdy    = '1;
        cxu_req_rdy = 1'b1;
        for (int c = 0; c < 6; c++) begin
            req_v         = (c < 4) ? 4'b0101 : 4'b0000;
            cxu_resp_v    = (c >= 2);
            rd            = {1'b1, $urandom};
            cxu_resp_data = rd;
            #1;
            if (c >= 2) begin
                h = id_q.pop_front();
                checks++;
                if (resp_v !== 4'(1 << h) || resp_data !== rd || cxu_resp_rdy !== 1'b1) begin
                    errors++;
                    $display("FAIL rr_resp c=%0d: resp_v=%b data=%h rdy=%b exp resp_v=%b data=%h rdy=1",
                             c, resp_v, resp_data, cxu_resp_rdy, 4'(1 << h), rd);
                end
            end
            if (c < 4) begin
                e = model_win(req_v, exp_ptr);
                checks++;
                if (cxu_req_v !== 1'b1 || cxu_req_id !== 2'(e) || cxu_req_data !== pay(e) ||
                    req_rdy !== 4'(1 << e)) begin
                    errors++;
                    $display("FAIL rr_grant c=%0d: v=%b id=%0d data=%h rdy=%b exp v=1 id=%0d data=%h rdy=%b",
                             c, cxu_req_v, cxu_req_id, cxu_req_data, req_rdy, e, pay(e), 4'(1 << e));
                end
                id_q.push_back(e);
                exp_ptr = (e + 1) % N;
            end else begin
                checks++;
                if (cxu_req_v !== 1'b0) begin
                    errors++;
                    $display("FAIL rr_idle c=%0d: cxu_req_v=%b exp 0", c, cxu_req_v);
                end
            end
            tick();
        end
    endtask

    task automatic test_stall();
        do_reset();
        cxu_req_rdy = 1'b0;
        req_v       = 4'b0100;
        #1;
        checks++;
        if (cxu_req_v !== 1'b1 || cxu_req_id !== 2'd2 || req_rdy !== 4'b0000) begin
            errors++;
            $display("FAIL lock_first: v=%b id=%0d rdy=%b exp v=1 id=2 rdy=0000", cxu_req_v, cxu_req_id, req_rdy);
        end
        tick();
        req_v = 4'b1111;
        #1;
        checks++;
        if (cxu_req_id !== 2'd2 || cxu_req_data !== pay(2)) begin
            errors++;
            $display("FAIL lock_hold: id=%0d data=%h exp id=2 data=%h", cxu_req_id, cxu_req_data, pay(2));
        end
        cxu_req_rdy = 1'b1;
        #1;
        checks++;
        if (req_rdy !== 4'b0100) begin
            errors++;
            $display("FAIL lock_rdy: req_rdy=%b exp 0100", req_rdy);
        end
        tick();

        do_reset();
        req_v = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            cxu_req_rdy = (c == 3);
            #1;
            checks++;
            if (cxu_req_v !== 1'b1 || cxu_req_id !== 2'd0 || cxu_req_data !== pay(0) ||
                req_rdy !== ((c == 3) ? 4'b0001 : 4'b0000)) begin
                errors++;
                $display("FAIL stall c=%0d: v=%b id=%0d data=%h rdy=%b exp v=1 id=0 data=%h rdy=%b",
                         c, cxu_req_v, cxu_req_id, cxu_req_data, req_rdy, pay(0),
                         (c == 3) ? 4'b0001 : 4'b0000);
            end
            tick();
        end
        cxu_req_rdy = 1'b0;
        #1;
        checks++;
        if (cxu_req_id !== 2'd1) begin
            errors++;
            $display("FAIL stall_next: id=%0d exp 1", cxu_req_id);
        end
    endtask

    task automatic test_full();
        int e;
        do_reset();
        req_v       = 4'b1111;
        cxu_req_rdy = 1'b1;
        resp_rdy    = '1;
        for (int c = 0; c < 4; c++) begin
            e = model_win(req_v, exp_ptr);
            #1;
            checks++;
            if (cxu_req_id !== 2'(e) || req_rdy !== 4'(1 << e)) begin
                errors++;
                $display("FAIL fill c=%0d: id=%0d rdy=%b exp id=%0d rdy=%b", c, cxu_req_id, req_rdy, e, 4'(1 << e));
            end
            id_q.push_back(e);
            exp_ptr = (e + 1) % N;
            tick();
        end
        #1;
        checks++;
        if (cxu_req_v !== 1'b0 || req_rdy !== 4'b0000) begin
            errors++;
            $display("FAIL full_stall: v=%b rdy=%b exp v=0 rdy=0000", cxu_req_v, req_rdy);
        end
        tick();
        cxu_resp_v = 1'b1;
        e = model_win(req_v, exp_ptr);
        #1;
        checks++;
        if (resp_v !== 4'(1 << id_q[0]) || cxu_req_v !== 1'b1 || cxu_req_id !== 2'(e) ||
            req_rdy !== 4'(1 << e)) begin
            errors++;
            $display("FAIL full_swap: resp_v=%b v=%b id=%0d rdy=%b exp resp_v=%b v=1 id=%0d rdy=%b",
                     resp_v, cxu_req_v, cxu_req_id, req_rdy, 4'(1 << id_q[0]), e, 4'(1 << e));
        end
        void'(id_q.pop_front());
        id_q.push_back(e);
        exp_ptr = (e + 1) % N;
        tick();
        cxu_resp_v = 1'b0;
        #1;
        checks++;
        if (cxu_req_v !== 1'b0) begin
            errors++;
            $display("FAIL full_count: cxu_req_v=%b exp 0", cxu_req_v);
        end
        tick();
        req_v      = '0;
        cxu_resp_v = 1'b1;
        while (id_q.size() > 0) begin
            e = id_q.pop_front();
            #1;
            checks++;
            if (resp_v !== 4'(1 << e)) begin
                errors++;
                $display("FAIL drain: resp_v=%b exp %b", resp_v, 4'(1 << e));
            end
            tick();
        end
        cxu_resp_v = 1'b0;
        resp_rdy   = '0;
        #1;
        checks++;
        if (cxu_resp_rdy !== 1'b1) begin
            errors++;
            $display("FAIL drain_empty: cxu_resp_rdy=%b exp 1", cxu_resp_rdy);
        end
    endtask

    task automatic test_resp_stall();
        int e;
        do_reset();
        cxu_req_rdy = 1'b1;
        req_v       = 4'b1000;
        id_q.push_back(model_win(req_v, exp_ptr));
        exp_ptr = (id_q[$] + 1) % N;
        tick();
        req_v = 4'b0010;
        id_q.push_back(model_win(req_v, exp_ptr));
        tick();
        req_v       = '0;
        cxu_req_rdy = 1'b0;
        cxu_resp_v  = 1'b1;
        e = id_q.pop_front();
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (resp_v !== 4'(1 << e) || cxu_resp_rdy !== 1'b0) begin
                errors++;
                $display("FAIL resp_hold c=%0d: resp_v=%b rdy=%b exp resp_v=%b rdy=0", c, resp_v, cxu_resp_rdy, 4'(1 << e));
            end
            tick();
        end
        resp_rdy = 4'(1 << e);
        #1;
        checks++;
        if (resp_v !== 4'(1 << e) || cxu_resp_rdy !== 1'b1) begin
            errors++;
            $display("FAIL resp_go: resp_v=%b rdy=%b exp resp_v=%b rdy=1", resp_v, cxu_resp_rdy, 4'(1 << e));
        end
        tick();
        e = id_q.pop_front();
        resp_rdy = '0;
        #1;
        checks++;
        if (resp_v !== 4'(1 << e) || cxu_resp_rdy !== 1'b0) begin
            errors++;
            $display("FAIL resp_second: resp_v=%b rdy=%b exp resp_v=%b rdy=0", resp_v, cxu_resp_rdy, 4'(1 << e));
        end
        resp_rdy = 4'(1 << e);
        tick();
        cxu_resp_v = 1'b0;
        resp_rdy   = '0;
        #1;
        checks++;
        if (cxu_resp_rdy !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL resp_done: cxu_resp_rdy=%b err=%b exp 1 0", cxu_resp_rdy, err);
        end
    endtask

    task automatic test_empty_err();
        do_reset();
        cxu_resp_v = 1'b1;
        #1;
        checks++;
        if (cxu_resp_rdy !== 1'b1 || resp_v !== 4'b0000 || err !== 1'b0) begin
            errors++;
            $display("FAIL empty_resp: rdy=%b resp_v=%b err=%b exp 1 0000 0", cxu_resp_rdy, resp_v, err);
        end
        tick();
        cxu_resp_v = 1'b0;
        #1;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_rise: err=%b exp 1", err);
        end
        tick();
        tick();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: err=%b exp 1", err);
        end
        do_reset();
        #1;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: err=%b exp 0", err);
        end
    endtask

    task automatic test_reset_locked();
        do_reset();
        cxu_req_rdy = 1'b1;
        req_v       = 4'b0011;
        tick();
        tick();
        cxu_req_rdy = 1'b0;
        req_v       = 4'b1111;
        #1;
        checks++;
        if (cxu_req_id !== 2'd2 || cxu_req_v !== 1'b1) begin
            errors++;
            $display("FAIL pre_lock: id=%0d v=%b exp id=2 v=1", cxu_req_id, cxu_req_v);
        end
        tick();
        rst_n       = 1'b0;
        cxu_req_rdy = 1'b1;
        cxu_resp_v  = 1'b1;
        resp_rdy    = '1;
        #1;
        checks++;
        if ({req_rdy, cxu_req_v, cxu_resp_rdy, resp_v} !== 10'b0) begin
            errors++;
            $display("FAIL mid_reset: req_rdy=%b v=%b resp_rdy=%b resp_v=%b exp all 0",
                     req_rdy, cxu_req_v, cxu_resp_rdy, resp_v);
        end
        tick();
        rst_n       = 1'b1;
        cxu_resp_v  = 1'b0;
        resp_rdy    = '0;
        cxu_req_rdy = 1'b0;
        #1;
        checks++;
        if (cxu_req_id !== 2'd0 || cxu_req_v !== 1'b1 || cxu_resp_rdy !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: id=%0d v=%b resp_rdy=%b err=%b exp 0 1 1 0",
                     cxu_req_id, cxu_req_v, cxu_resp_rdy, err);
        end
        tick();
    endtask

    initial begin
        for (int i = 0; i < N; i++) req_data[i*RW +: RW] = pay(i);
        idle_inputs();
        test_reset();
        test_round_robin();
        test_stall();
        test_full();
        test_resp_stall();
        test_empty_err();
        test_reset_locked();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
